// File: rtl/kgp_mux_pkg.sv
// Shared definitions for the channel-select pipeline.
package kgp_mux_pkg;

    // Encodings for the mode input.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way selector. It flags selects that have no matching channel.
module mux_n_comb #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out,
    output logic               err
);

    // An unmatched select (sel >= N) falls through to zero data with err set.
    always_comb begin
        out = '0;
        err = 1'b1;
        for (int k = 0; k < int'(N); k++) begin
            if (sel == SEL_W'(k)) begin
                out = in_flat[k*WIDTH +: WIDTH];
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-channel mux that offers direct or round-robin selection.
// The selected beat is held in a one-deep valid/ready output register.
module mux_n_pipe
    import kgp_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] eff_sel;
    logic [SEL_W-1:0] rr_next;
    logic [WIDTH-1:0] mux_out;
    logic             mux_err;
    logic             accept;

    // The output register can take a beat when it is empty or is draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign eff_sel  = (mode == MODE_RR) ? rr_ptr : sel;
    assign rr_next  = (rr_ptr == SEL_W'(N - 1)) ? '0 : rr_ptr + SEL_W'(1);

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_sel (
        .in_flat (in_flat),
        .sel     (eff_sel),
        .out     (mux_out),
        .err     (mux_err)
    );

    // Output beat register. A consume with no new beat clears only the valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_sel   <= eff_sel;
            out_err   <= mux_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // The round-robin pointer moves only on beats accepted in round-robin mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept && (mode == MODE_RR)) begin
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe that drives a 4-channel and a 3-channel instance.
module tb_mux_n_pipe;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4*W-1:0] flat4;
    logic [1:0]     sel4, os4;
    logic           mode4, iv4, ir4, ov4, or4, oe4;
    logic [W-1:0]   od4;

    logic [3*W-1:0] flat3;
    logic [1:0]     sel3, os3;
    logic           mode3, iv3, ir3, ov3, or3, oe3;
    logic [W-1:0]   od3;

    exp_t q4[$];
    exp_t q3[$];
    exp_t m4, m3;
    int   n_pass = 0;
    int   n_total = 0;
    int   deliv4 = 0;

    mux_n_pipe #(.WIDTH(W), .N(4)) dut4 (
        .clk(clk), .rst(rst), .in_flat(flat4), .sel(sel4), .mode(mode4),
        .in_valid(iv4), .in_ready(ir4), .out_data(od4), .out_sel(os4),
        .out_err(oe4), .out_valid(ov4), .out_ready(or4)
    );

    mux_n_pipe #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst(rst), .in_flat(flat3), .sel(sel3), .mode(mode3),
        .in_valid(iv3), .in_ready(ir3), .out_data(od3), .out_sel(os3),
        .out_err(oe3), .out_valid(ov3), .out_ready(or3)
    );

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    // Monitors: a beat is consumed at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) begin
                n_total++;
                $display("FAIL mon4_unexpected: got beat data %0d sel %0d, required none", od4, os4);
            end else begin
                m4 = q4.pop_front();
                check("mon4_data", int'(od4), int'(m4.d));
                check("mon4_sel", int'(os4), int'(m4.s));
                check("mon4_err", int'(oe4), int'(m4.e));
                deliv4++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov3 && or3) begin
            if (q3.size() == 0) begin
                n_total++;
                $display("FAIL mon3_unexpected: got beat data %0d sel %0d, required none", od3, os3);
            end else begin
                m3 = q3.pop_front();
                check("mon3_data", int'(od3), int'(m3.d));
                check("mon3_sel", int'(os3), int'(m3.s));
                check("mon3_err", int'(oe3), int'(m3.e));
            end
        end
    end

    // One beat on dut4: offered at posedge+1, accepted at the following edge.
    task automatic beat4(input logic m, input logic [1:0] s, input logic [W-1:0] ed, input logic [1:0] es);
        exp_t x;
        mode4 = m;
        sel4  = s;
        iv4   = 1'b1;
        @(negedge clk);
        check("in_ready4", int'(ir4), 1);
        x.d = ed;
        x.s = es;
        x.e = 1'b0;
        q4.push_back(x);
        @(posedge clk);
        #1;
        iv4 = 1'b0;
    endtask

    task automatic beat3(input logic m, input logic [1:0] s, input logic [W-1:0] ed,
                         input logic [1:0] es, input logic ee);
        exp_t x;
        mode3 = m;
        sel3  = s;
        iv3   = 1'b1;
        @(negedge clk);
        check("in_ready3", int'(ir3), 1);
        x.d = ed;
        x.s = es;
        x.e = ee;
        q3.push_back(x);
        @(posedge clk);
        #1;
        iv3 = 1'b0;
    endtask

    initial begin
        automatic int rr_sel[6]  = '{0, 1, 2, 3, 0, 1};
        automatic int rr_dat[6]  = '{10, 20, 30, 40, 10, 20};
        automatic int r3_sel[4]  = '{0, 1, 2, 0};
        automatic int r3_dat[4]  = '{11, 22, 33, 11};
        automatic int start;
        automatic int budget;

        rst = 1'b1;
        flat4 = '0; sel4 = '0; mode4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;
        flat3 = '0; sel3 = '0; mode3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and first cycle out of reset
        @(negedge clk);
        check("rst_valid", int'(ov4), 0);
        check("rst_data", int'(od4), 0);
        check("rst_sel", int'(os4), 0);
        check("rst_err", int'(oe4), 0);
        check("rst_in_ready", int'(ir4), 1);
        @(posedge clk);
        #1;

        // Direct select of channel 2
        flat4 = {8'd40, 8'd30, 8'd20, 8'd10};
        beat4(1'b0, 2'd2, 8'd30, 2'd2);
        check("latency_valid", int'(ov4), 1);

        // Round-robin through the wrap
        for (int i = 0; i < 6; i++) begin
            beat4(1'b1, 2'd3, W'(rr_dat[i]), 2'(rr_sel[i]));
        end
        @(posedge clk);
        #1;

        // Reset while a beat is held and another is offered
        or4 = 1'b0;
        beat4(1'b0, 2'd3, 8'd40, 2'd3);
        @(negedge clk);
        check("held_valid", int'(ov4), 1);
        @(posedge clk);
        #1;
        rst = 1'b1; iv4 = 1'b1; mode4 = 1'b1; or4 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; iv4 = 1'b0;
        q4.delete();
        @(negedge clk);
        check("midrst_valid", int'(ov4), 0);
        check("midrst_data", int'(od4), 0);
        check("midrst_in_ready", int'(ir4), 1);
        @(posedge clk);
        #1;
        beat4(1'b1, 2'd3, 8'd10, 2'd0);
        @(posedge clk);
        #1;

        // Backpressure: held beat stays put while inputs churn
        or4 = 1'b0;
        flat4 = {8'd40, 8'd30, 8'd20, 8'd10};
        beat4(1'b0, 2'd1, 8'd20, 2'd1);
        mode4 = 1'b1;
        iv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flat4 = {8'(90 + i), 8'(91 + i), 8'(92 + i), 8'(93 + i)};
            sel4 = 2'(i);
            @(negedge clk);
            check("bp_data", int'(od4), 20);
            check("bp_sel", int'(os4), 1);
            check("bp_valid", int'(ov4), 1);
            check("bp_in_ready", int'(ir4), 0);
            @(posedge clk);
            #1;
        end
        // Consume and accept in the same edge; rr pointer still at 1
        flat4 = {8'd80, 8'd70, 8'd60, 8'd50};
        or4 = 1'b1;
        beat4(1'b1, 2'd0, 8'd60, 2'd1);
        check("replace_valid", int'(ov4), 1);
        @(posedge clk);
        #1;
        check("drain_valid", int'(ov4), 0);
        check("drain_hold_data", int'(od4), 60);

        // Throughput: ten back-to-back beats
        start = deliv4;
        for (int i = 0; i < 10; i++) begin
            flat4 = '0;
            flat4[(i % 4)*W +: W] = W'(100 + i);
            beat4(1'b0, 2'(i % 4), W'(100 + i), 2'(i % 4));
            check("tput_valid", int'(ov4), 1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("tput_count", deliv4 - start, 10);

        // Three-channel instance: out-of-range select, then round-robin wrap
        flat3 = {8'd33, 8'd22, 8'd11};
        beat3(1'b0, 2'd3, 8'd0, 2'd3, 1'b1);
        beat3(1'b0, 2'd2, 8'd33, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            beat3(1'b1, 2'd3, W'(r3_dat[i]), 2'(r3_sel[i]), 1'b0);
        end

        budget = 0;
        while ((q4.size() != 0 || q3.size() != 0) && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("drain_q4", q4.size(), 0);
        check("drain_q3", q3.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width of each input and of the output.
REQ-002 The block SHALL have parameter N, default 4, the number of input channels (N >= 2).
REQ-003 The block SHALL have derived constant SEL_W, value clog2(N), the select width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_flat  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel index in direct mode; ignored in round-robin mode.
REQ-008 mode  input  1  0 = direct select, 1 = round-robin.
REQ-009 in_valid  input  1  upstream beat offered.
REQ-010 in_ready  output  1  block can accept a beat this cycle.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_sel  output  SEL_W  channel index that produced out_data.
REQ-013 out_err  output  1  beat was produced from an out-of-range select.
REQ-014 out_valid  output  1  out_data/out_sel/out_err hold a beat.
REQ-015 out_ready  input  1  downstream consumes the beat.

Function
REQ-016 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) combinationally; no bubble on back-to-back transfers.
REQ-018 Latency SHALL be exactly 1 cycle: an accepted beat appears on out_* with out_valid=1 the following cycle.
REQ-019 Effective index SHALL be sel in mode 0, rr_ptr in mode 1, sampled in the accepting cycle.
REQ-020 out_data SHALL load in_flat channel [effective index]; out_sel SHALL load the effective index.
REQ-021 In mode 0 with sel >= N (non-power-of-2 N), out_data SHALL load 0 and out_err SHALL load 1; otherwise out_err loads 0.
REQ-022 rr_ptr SHALL advance by 1 on each accepted beat in mode 1, wrapping from N-1 to 0; it SHALL hold when no beat is accepted or mode=0.
REQ-023 rr_ptr SHALL hold its value across mode changes; mode change takes effect on the next accepted beat.
REQ-024 When out_valid=1 and out_ready=0, out_data, out_sel, out_err SHALL remain stable and in_ready SHALL be 0.
REQ-025 When out_valid=1, out_ready=1 and no new beat is accepted, out_valid SHALL clear on the next edge; out_data SHALL hold its last value.
REQ-026 Simultaneous consume and accept SHALL replace the output beat in one cycle with out_valid staying 1.
REQ-027 in_flat and sel changes while no beat is accepted SHALL NOT affect out_*.

Reset
REQ-028 rst=1 at a rising edge SHALL set out_valid=0, out_data=0, out_sel=0, out_err=0, rr_ptr=0.
REQ-029 Reset SHALL override a simultaneous accept; a beat in flight or held SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 Mode encodings MODE_DIRECT=0 and MODE_RR=1 SHALL be defined in shared package kgp_mux_pkg.
REQ-032 Selection SHALL be a combinational sub-module mux_n_comb (parameters WIDTH, N; ports in_flat, sel, out, err); handshake register and rr_ptr live in mux_n_pipe.

Verification
REQ-033 Direct: N=4, channels {10,20,30,40}, mode=0, sel=2, in_valid=1, out_ready=1 -> next cycle out_data=30, out_sel=2, out_valid=1, out_err=0.
REQ-034 Round-robin wrap: mode=1, 6 consecutive accepted beats, out_ready=1 -> out_sel sequence 0,1,2,3,0,1; rr_ptr ends at 2.
REQ-035 Backpressure: beat with out_data=20 held, out_ready=0 for 3 cycles while in_flat changes -> out_data stays 20, in_ready=0, rr_ptr unchanged.
REQ-036 Out-of-range: N=3, mode=0, sel=3 -> out_data=0, out_err=1, out_sel=3.
REQ-037 Reset mid-operation: out_valid=1, rr_ptr=2, rst=1 for one edge with in_valid=1 -> out_valid=0, out_data=0, rr_ptr=0; next accept in mode 1 gives out_sel=0.
REQ-038 Throughput: WIDTH=8, in_valid=1, out_ready=1 for 10 cycles -> 10 beats delivered, out_valid continuously 1 after first cycle.
